// File: rtl/esp_wait_ctrl.sv
// esp_wait_ctrl: turns a bus select edge into an ESP_REQ pulse and holds Z80 WAIT until ESP_DONE or timeout
module esp_wait_ctrl #(
   parameter int REQ_PULSE = 50,
   parameter int TIMEOUT = 10_000_000
) (
   input logic clk,
   input logic rst,
   input logic sel_in,
   input logic [2:0] sel_type,
   input logic esp_done,
   input logic clear_err,
   output logic esp_req,
   output logic [2:0] esp_s,
   output logic wait_out,
   output logic busy,
   output logic timeout_err,
   output logic [7:0] req_count
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, HOLD} state_t;
   localparam logic [23:0] T_LAST = 24'(TIMEOUT - 1);
   localparam logic [7:0] P_LOAD = 8'(REQ_PULSE);
   state_t state, nxt;
   logic [2:0] sel_sh, done_sh;
   logic sel_rise, done_rise, done_early;
   logic [7:0] pcnt;
   logic [23:0] tcnt;
   logic fin, tmo, dn, accept, set_err;
   always_comb begin
      fin = pcnt == 8'd1;
      tmo = tcnt == T_LAST;
      dn = done_early | done_rise;
      nxt = state;
      accept = 1'b0;
      set_err = 1'b0;
      case (state)
         IDLE: begin
            accept = sel_rise;
            nxt = sel_rise ? REQ : IDLE;
         end
         REQ: begin
            nxt = (fin | tmo) ? ((dn | tmo) ? HOLD : WAIT_DONE) : REQ;
            set_err = tmo & ~dn;
         end
         WAIT_DONE: begin
            nxt = (done_rise | tmo) ? HOLD : WAIT_DONE;
            set_err = tmo & ~done_rise;
         end
         default: nxt = sel_sh[1] ? HOLD : IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_sh <= '1;
         done_sh <= '1;
         sel_rise <= 1'b0;
         done_rise <= 1'b0;
         state <= IDLE;
         pcnt <= '0;
         tcnt <= '0;
         done_early <= 1'b0;
         esp_s <= '0;
         req_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         sel_sh <= {sel_sh[1:0], sel_in};
         done_sh <= {done_sh[1:0], esp_done};
         sel_rise <= sel_sh[1] & ~sel_sh[2];
         done_rise <= done_sh[1] & ~done_sh[2];
         state <= nxt;
         pcnt <= accept ? P_LOAD : (state == REQ) ? pcnt - 8'd1 : pcnt;
         tcnt <= accept ? '0 : (state == REQ || state == WAIT_DONE) ? tcnt + 24'd1 : tcnt;
         done_early <= accept ? 1'b0 : (state == REQ) ? (done_early | done_rise) : done_early;
         esp_s <= accept ? sel_type : esp_s;
         req_count <= accept ? req_count + 8'd1 : req_count;
         timeout_err <= set_err | (timeout_err & ~clear_err);
      end
   end
   assign esp_req = state == REQ;
   assign wait_out = state == REQ || state == WAIT_DONE;
   assign busy = state != IDLE;
endmodule

// File: tb/tb_esp_wait_ctrl.sv
// tb_esp_wait_ctrl: table-driven scoreboard bench for esp_wait_ctrl
module tb_esp_wait_ctrl;
   localparam int P = 50, T = 1000;
   logic clk = 0, rst = 1, sel_in = 0, esp_done = 0, clear_err = 0;
   logic [2:0] sel_type = 0, esp_s;
   logic esp_req, wait_out, busy, timeout_err;
   logic [7:0] req_count;
   int cyc = 0, tests = 0, fails = 0, exp_cnt = 0, req_pulses = 0;
   int req_rise = 0, req_fall = 0, wait_rise = 0;
   logic req_q = 0, wait_q = 0, mon_en = 1;
   typedef struct { logic [2:0] typ; int off; int hold; int wait_w; logic err; } vec_t;
   typedef struct { logic [2:0] typ; int wait_w; logic err; } exp_t;
   exp_t sb[$];
   exp_t m;
   vec_t vec[9];

   esp_wait_ctrl #(.REQ_PULSE(P), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .sel_in(sel_in), .sel_type(sel_type), .esp_done(esp_done),
      .clear_err(clear_err), .esp_req(esp_req), .esp_s(esp_s), .wait_out(wait_out),
      .busy(busy), .timeout_err(timeout_err), .req_count(req_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", n, a, e, cyc);
      end
   endtask

   // Release of WAIT pops the scoreboard entry pushed when the request was driven.
   always @(negedge clk) begin
      if (esp_req && !req_q) begin
         req_rise = cyc;
         req_pulses++;
      end
      if (!esp_req && req_q) req_fall = cyc;
      if (wait_out && !wait_q) wait_rise = cyc;
      if (!wait_out && wait_q && mon_en) begin
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            m = sb.pop_front();
            chk("req_width", req_fall - req_rise, P);
            chk("wait_rise", wait_rise, req_rise);
            chk("wait_width", cyc - wait_rise, m.wait_w);
            chk("esp_s", esp_s, m.typ);
            chk("timeout_err", timeout_err, m.err);
         end
      end
      req_q = esp_req;
      wait_q = wait_out;
   end

   task automatic run_req(input vec_t v);
      int p0;
      p0 = req_pulses;
      sb.push_back('{v.typ, v.wait_w, v.err});
      sel_type = v.typ;
      sel_in = 1;
      exp_cnt++;
      if (v.off > 0) begin
         repeat (v.off) @(posedge clk);
         #1 esp_done = 1;
      end
      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
      chk("release_bound", sb.size(), 0);
      sb.delete();
      repeat (v.hold + 1) @(posedge clk);
      #1 sel_in = 0;
      esp_done = 0;
      repeat (2) @(posedge clk);
      #1 chk("busy_hold", busy, 1);
      @(posedge clk);
      #1 chk("busy_exit", busy, 0);
      chk("one_pulse", req_pulses - p0, 1);
      chk("req_count", req_count, exp_cnt % 256);
      if (v.err) begin
         clear_err = 1;
         @(posedge clk);
         #1 clear_err = 0;
         chk("clear_err", timeout_err, 0);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      vec[0] = '{3'd3, 190, 0, 190, 1'b0};
      vec[1] = '{3'd1, 10, 0, 50, 1'b0};
      vec[2] = '{3'd2, -1, 0, 1000, 1'b1};
      vec[3] = '{3'd0, 52, 0, 52, 1'b0};
      vec[4] = '{3'd4, 50, 0, 50, 1'b0};
      vec[5] = '{3'd4, 49, 0, 50, 1'b0};
      vec[6] = '{3'd3, 1000, 0, 1000, 1'b0};
      vec[7] = '{3'd1, 1001, 0, 1000, 1'b1};
      vec[8] = '{3'd1, 100, 5000, 100, 1'b0};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_esp_req", esp_req, 0);
      chk("rst_wait", wait_out, 0);
      chk("rst_esp_s", esp_s, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_count", req_count, 0);
      rst = 0;
      repeat (5) @(posedge clk);
      #1;
      foreach (vec[i]) run_req(vec[i]);
      mon_en = 0;
      sel_type = 3'd2;
      sel_in = 1;
      repeat (70) @(posedge clk);
      #1 chk("mid_wait", wait_out, 1);
      chk("mid_req", esp_req, 0);
      rst = 1;
      @(posedge clk);
      #1 chk("mid_rst_wait", wait_out, 0);
      chk("mid_rst_req", esp_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_esp_s", esp_s, 0);
      chk("mid_rst_count", req_count, 0);
      rst = 0;
      repeat (20) @(posedge clk);
      #1 chk("rel_busy", busy, 0);
      chk("rel_req", esp_req, 0);
      chk("rel_count", req_count, 0);
      sel_in = 0;
      repeat (5) @(posedge clk);
      #1 mon_en = 1;
      exp_cnt = 0;
      for (int i = 0; i < 256; i++) run_req('{3'(i % 5), 5, 0, 50, 1'b0});
      chk("wrap_zero", req_count, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/esp_wait_ctrl.md
# esp_wait_ctrl

Handshake stage between the TRS-80 bus select decode and the ESP32. It turns a rising edge on the combined ESP select (TRS-IO port 31, FreHD ports 0xC0–0xCF) into a fixed-width ESP_REQ pulse, latches the request type onto ESP_S, and holds the Z80 WAIT line. WAIT is released on the ESP_DONE rising edge, or on a timeout so that a hung ESP cannot freeze the bus. The block is the downstream consumer of the select decode and drives the ESP pins directly.

## Interface
- `REQ_PULSE`, default 50: ESP_REQ high time in clk cycles; valid range 2..255.
- `TIMEOUT`, default 10_000_000: cycles from request start to forced WAIT release (100 ms at 100 MHz); valid range 1..2^24−1.
- `clk` in 1: 100 MHz system clock. Everything is single-clock.
- `rst` in 1: synchronous, active-high reset.
- `sel_in` in 1: combinational ESP select from bus decode; asynchronous to clk.
- `sel_type` in 3: request code valid while `sel_in` is high (0 trs_io_in, 1 trs_io_out, 2 frehd_in, 3 frehd_out, 4 fdc_rd).
- `esp_done` in 1: ESP_DONE pin; asynchronous.
- `clear_err` in 1: one-cycle pulse that clears `timeout_err`.
- `esp_req` out 1: request pulse to the ESP.
- `esp_s` out 3: latched request code.
- `wait_out` out 1: Z80 WAIT drive (1 = hold the CPU).
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: sticky flag, set when a timeout occurs.
- `req_count` out 8: number of accepted requests, wraps at 255→0.

## Operation
- **Synchronizers.** `sel_in` and `esp_done` each pass through 2 flops, plus a third "previous" flop used for edge detection. Reset loads all six flops with 1, so an input already high when reset releases is not seen as an edge.
- **State: IDLE.** On a `sel` rising edge:
  - latch `sel_type` into `esp_s`;
  - set `esp_req` = 1 and `wait_out` = 1;
  - load pulse counter with `REQ_PULSE`, clear timeout counter;
  - increment `req_count`;
  - go to REQ.
- **State: REQ.**
  - Pulse counter decrements each cycle. When it reaches 1: `esp_req` ← 0 and go to WAIT_DONE.
  - A `done` edge seen in REQ is recorded in a `done_early` flag. When the pulse ends in that case: `wait_out` ← 0 and go to HOLD instead of WAIT_DONE.
- **State: WAIT_DONE.**
  - On a `done` rising edge: `wait_out` ← 0, go to HOLD.
- **Timeout (REQ and WAIT_DONE).**
  - The 24-bit timeout counter increments in both states.
  - When it equals `TIMEOUT − 1`: `wait_out` ← 0, `esp_req` ← 0, `timeout_err` ← 1, go to HOLD.
  - If timeout and `done` fall on the same cycle, `done` wins and `timeout_err` is not set.
- **State: HOLD.** Wait for synchronized `sel` to be 0, then go to IDLE. This makes one bus cycle produce exactly one request.
- **Select behaviour outside IDLE.**
  - `sel` edges are ignored in REQ, WAIT_DONE and HOLD.
  - `sel` falling during REQ or WAIT_DONE does not abort the request.
- **`esp_s`** holds its value until the next accepted request.
- **`clear_err`:** clears `timeout_err`. If a set and a clear happen in the same cycle, the set wins.
- **`rst` mid-operation:** everything returns to IDLE immediately, and `wait_out` drops on the next edge.

## Timing
- **Reset values:**
  - `esp_req` 0, `wait_out` 0, `esp_s` 0, `busy` 0, `timeout_err` 0, `req_count` 0;
  - state IDLE;
  - all counters 0.
- **`sel_in` rise to outputs.** If `sel_in` is stable high at edge k:
  - the edge is detected at edge k+2;
  - `esp_req`, `wait_out`, `esp_s` and `busy` are high after edge k+3 (3-cycle latency).
- **`esp_req` width:** exactly `REQ_PULSE` cycles.
- **`esp_done` rise to release.** If `esp_done` is stable high at edge k and the state is WAIT_DONE, `wait_out` is 0 after edge k+3.
- **Timeout release:** `wait_out` falls `TIMEOUT` cycles after it rose.
- **Early done:** `wait_out` falls on the same edge that `esp_req` falls.
- **Back-to-back requests:** minimum spacing is HOLD exit plus 3 cycles. No edge is lost as long as `sel_in` stays low for at least 2 cycles.

## Test plan
- **Basic request/done.** `sel_type`=3 with `sel_in` rising at cycle 10; `esp_done` rises at cycle 200.
  - Required: `esp_req` high on cycles 13–62; `esp_s`=3; `wait_out` high from 13 until 203; `req_count`=1.
- **Early done.** `esp_done` rises at cycle 20, during the pulse.
  - Required: `wait_out` and `esp_req` both fall at cycle 63; no `timeout_err`.
- **Timeout** (`TIMEOUT`=1000). No `esp_done`.
  - Required: `wait_out` falls 1000 cycles after it rose; `timeout_err`=1.
  - Then pulse `clear_err` → `timeout_err`=0.
- **Held select / no re-trigger.** `sel_in` stays high for 5000 cycles after done.
  - Required: exactly one `esp_req` pulse; `busy` stays high until `sel` goes low + 2 cycles.
  - Then a second `sel` rise → `req_count`=2.
- **Reset.**
  - Assert `rst` in WAIT_DONE: all outputs 0 next cycle.
  - Release `rst` with `sel_in` still high: no request is issued.
- **`req_count` wrap.** 256 complete requests → `req_count` reads 0.
  - Same-cycle timeout and done → `timeout_err` stays 0.
